rans_bit_reader: RTL and testbench
==================================

// Module: rans_bit_reader
// PURPOSE
// - Bitstream front end for the rANS decoder datapath.
// - Accepts packed WORD_WIDTH-bit words from the memory/stream interface with a valid/ready handshake.
// - Buffers them and serves variable-length MSB-first bit pulls, 0..MAX_PULL bits.
// - The decoder's state-expand (renormalisation) step consumes the pulls; pull_data is left-shifted into its state LSBs.
// PARAMETERS
// - WORD_WIDTH   32   input word width; first stream bit = in_word[WORD_WIDTH-1]
// - MAX_PULL     16   max bits per pull; must be <= WORD_WIDTH
// - LEN_WIDTH    $clog2(MAX_PULL+1)   width of pull_len
// - BUF_WIDTH    2*WORD_WIDTH   internal bit buffer capacity (localparam)
// PORTS
// - clk            in   1                clock, all logic on posedge
// - rst            in   1                synchronous reset, active-high
// - flush          in   1                sync clear of buffer/flags; next stream starts next cycle
// - in_word        in   WORD_WIDTH       packed stream word
// - in_valid       in   1                in_word valid
// - in_last        in   1                this word is final; qualified by in_valid
// - in_last_bits   in   $clog2(WORD_WIDTH+1)  valid MSBs in final word; 0 means WORD_WIDTH
// - in_ready       out  1                word accepted when in_valid && in_ready
// - pull_req       in   1                decoder requests pull_len bits
// - pull_len       in   LEN_WIDTH        bits requested; values > MAX_PULL clamp to MAX_PULL
// - pull_ack       out  1                combinational; pull performed this cycle
// - pull_data      out  MAX_PULL         combinational; right-aligned pulled bits, upper bits 0
// - eos            out  1                last word accepted and buffer count == 0
// - underflow      out  1                sticky; pull served with zero padding past end of stream
// BEHAVIOUR
// - Buffer is left-aligned: valid bits are buf[BUF_WIDTH-1 -: count], with count in 0..BUF_WIDTH.
// - FSM S_RUN -> S_DRAIN -> S_DONE.
//   - S_RUN: accepting words.
//   - Accepted word with in_last moves to S_DRAIN.
//   - S_DRAIN with count reaching 0 moves to S_DONE.
//   - rst or flush forces S_RUN.
// - in_ready = (state==S_RUN) && (count <= BUF_WIDTH-WORD_WIDTH).
//   - Uses the pre-pull count: conservative, no combinational path from pull to in_ready.
// - pull_ack:
//   - pull_req && (count >= len): normal pull.
//   - pull_req && state!=S_RUN && count < len: short pull. Returns the remaining count bits MSB-first, then zeros; count becomes 0; underflow is set.
//   - pull_req && state==S_RUN && count < len: pull_ack=0, no change. Decoder holds the request.
// - pull_len==0 with pull_req: pull_ack=1, pull_data=0, no state change.
// - Pull data equals the top len buffer bits, right-aligned. Buffer shifts left by len; count -= len.
// - Simultaneous accept and pull in one cycle:
//   - Pull is applied first.
//   - The word is appended at bit position BUF_WIDTH-1-(count-len).
//   - Next count = count - len + word_bits.
// - Final word contributes in_last_bits bits; lower garbage bits are ignored (masked).
// - eos = (state != S_RUN) && (count==0). Pulls in S_DONE return 0 and set underflow.
// - Reset / flush: count=0, buffer=0, underflow=0, state=S_RUN.
//   - Any pull in the same cycle is ignored; pull_ack=0.
//   - Any input word in the same cycle is dropped.
// - Output reset values: in_ready=1, pull_ack=0, pull_data=0, eos=0, underflow=0.
// - Latency: an accepted word is pullable the next cycle; a pull is single-cycle.
// CONFIGURATION
// - RANS_BITREAD_STATS_EN defined:
//   - Adds output bits_consumed [31:0]: total bits delivered by acked pulls, excluding zero padding.
//   - Cleared by rst/flush; saturates at 2^32-1.
//   - Adds output words_accepted [31:0] with the same clear and saturate rules.
// - RANS_BITREAD_STATS_EN undefined: both ports and counters are absent; all other behaviour is identical.
// TESTING
// - After rst, word 0xDEADBEEF in, then pulls len 4,8,4,16:
//   - Data 0xD, 0xEA, 0xD, 0xBEEF.
//   - count 0 afterwards; in_ready=1 throughout.
// - Pull len 12 with count=0 in S_RUN: pull_ack=0 and stays 0.
//   - Word 0xABC00000 arrives; next cycle pull_ack=1, data 0xABC.
// - Backpressure: push 2 words without pulls. in_ready=0 at count 64.
//   - Pull len 16 in the same cycle as in_valid: word not accepted.
//   - Next cycle count 48; still blocked, since ready requires count <= 32.
// - Same-cycle accept and pull: count=16 holding 0x1234, word 0x55550000, pull len 8:
//   - data 0x12; next count 40; next 16-bit pull returns 0x3455.
// - Last word 0xF0000000 with in_last_bits 4, then pull len 8:
//   - data 0xF0, underflow=1, eos=1, state S_DONE, in_ready=0.
//   - flush then clears underflow and restores in_ready=1.
// - Stats: under RANS_BITREAD_STATS_EN, after the first test, bits_consumed=32 and words_accepted=1.
//   - After rst both read 0.

Source files
------------

// File: rtl/rans_bit_reader.sv
// Bitstream front end for the rANS decoder: buffers packed words and serves MSB-first variable-length pulls.
// Optional statistics counters are enabled by defining RANS_BITREAD_STATS_EN.
module rans_bit_reader #(
    parameter int WORD_WIDTH = 32,
    parameter int MAX_PULL   = 16,
    parameter int LEN_WIDTH  = $clog2(MAX_PULL + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [WORD_WIDTH-1:0]           in_word,
    input  logic                            in_valid,
    input  logic                            in_last,
    input  logic [$clog2(WORD_WIDTH+1)-1:0] in_last_bits,
    output logic                            in_ready,
    input  logic                            pull_req,
    input  logic [LEN_WIDTH-1:0]            pull_len,
    output logic                            pull_ack,
    output logic [MAX_PULL-1:0]             pull_data,
    output logic                            eos,
    output logic                            underflow
`ifdef RANS_BITREAD_STATS_EN
    ,
    output logic [31:0]                     bits_consumed,
    output logic [31:0]                     words_accepted
`endif
);

    localparam int BUF_WIDTH = 2 * WORD_WIDTH;
    localparam int CNT_WIDTH = $clog2(BUF_WIDTH + 1);
    localparam int LB_WIDTH  = $clog2(WORD_WIDTH + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [BUF_WIDTH-1:0]   buf_q, buf_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   underflow_q, underflow_d;

    logic [CNT_WIDTH-1:0]   lenClamped;
    logic                   haveEnough;
    logic [CNT_WIDTH-1:0]   consumed;
    logic [CNT_WIDTH-1:0]   wordBits;
    logic [WORD_WIDTH-1:0]  maskedWord;
    logic                   accept;

`ifdef RANS_BITREAD_STATS_EN
    logic [31:0]            bitsConsumed_q, bitsConsumed_d;
    logic [31:0]            wordsAccepted_q, wordsAccepted_d;
    logic [32:0]            bitsSum;
    logic [32:0]            wordsSum;

    assign bits_consumed  = bitsConsumed_q;
    assign words_accepted = wordsAccepted_q;
`endif

    // Readiness looks only at registered state so a pull never reaches in_ready combinationally.
    assign in_ready  = (state_q == S_RUN) && (count_q <= CNT_WIDTH'(BUF_WIDTH - WORD_WIDTH));
    assign eos       = (state_q != S_RUN) && (count_q == '0);
    assign underflow = underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            buf_q       <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef RANS_BITREAD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bitsConsumed_q  <= '0;
            wordsAccepted_q <= '0;
        end else begin
            bitsConsumed_q  <= bitsConsumed_d;
            wordsAccepted_q <= wordsAccepted_d;
        end
    end
`endif

    // Bits below the valid region are always zero, so a short pull pads with zeros for free.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        pull_ack    = 1'b0;
        pull_data   = '0;
        accept      = 1'b0;

        lenClamped = (pull_len > LEN_WIDTH'(MAX_PULL)) ? CNT_WIDTH'(MAX_PULL) : CNT_WIDTH'(pull_len);
        haveEnough = (count_q >= lenClamped);
        consumed   = haveEnough ? lenClamped : count_q;
        wordBits   = (in_last && (in_last_bits != '0) && (in_last_bits <= LB_WIDTH'(WORD_WIDTH)))
                     ? CNT_WIDTH'(in_last_bits) : CNT_WIDTH'(WORD_WIDTH);
        maskedWord = in_word & ~({WORD_WIDTH{1'b1}} >> wordBits);

`ifdef RANS_BITREAD_STATS_EN
        bitsConsumed_d  = bitsConsumed_q;
        wordsAccepted_d = wordsAccepted_q;
        bitsSum         = {1'b0, bitsConsumed_q} + 33'(consumed);
        wordsSum        = {1'b0, wordsAccepted_q} + 33'd1;
`endif

        if (rst || flush) begin
            state_d     = S_RUN;
            buf_d       = '0;
            count_d     = '0;
            underflow_d = 1'b0;
`ifdef RANS_BITREAD_STATS_EN
            bitsConsumed_d  = '0;
            wordsAccepted_d = '0;
`endif
        end else begin
            if (pull_req && (haveEnough || (state_q != S_RUN))) begin
                pull_ack  = 1'b1;
                pull_data = MAX_PULL'(buf_q >> (CNT_WIDTH'(BUF_WIDTH) - lenClamped));
                buf_d     = buf_q << lenClamped;
                count_d   = count_q - consumed;
                if (!haveEnough) begin
                    underflow_d = 1'b1;
                end
`ifdef RANS_BITREAD_STATS_EN
                bitsConsumed_d = bitsSum[32] ? 32'hFFFF_FFFF : bitsSum[31:0];
`endif
            end

            accept = in_valid && in_ready;
            if (accept) begin
                buf_d   = buf_d | ({maskedWord, {WORD_WIDTH{1'b0}}} >> count_d);
                count_d = count_d + wordBits;
                if (in_last) begin
                    state_d = S_DRAIN;
                end
`ifdef RANS_BITREAD_STATS_EN
                wordsAccepted_d = wordsSum[32] ? 32'hFFFF_FFFF : wordsSum[31:0];
`endif
            end

            if ((state_q == S_DRAIN) && (count_d == '0)) begin
                state_d = S_DONE;
            end
        end
    end

endmodule

// File: tb/tb_rans_bit_reader.sv
// Scoreboard bench for rans_bit_reader: a bit-queue reference model predicts every cycle's outputs.
// Stats ports are checked only when RANS_BITREAD_STATS_EN is defined.
module tb_rans_bit_reader;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_last;
    logic [5:0]  in_last_bits;
    logic        in_ready;
    logic        pull_req;
    logic [4:0]  pull_len;
    logic        pull_ack;
    logic [15:0] pull_data;
    logic        eos;
    logic        underflow;
`ifdef RANS_BITREAD_STATS_EN
    logic [31:0] bits_consumed;
    logic [31:0] words_accepted;
`endif

    rans_bit_reader dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_word      (in_word),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_last_bits (in_last_bits),
        .in_ready     (in_ready),
        .pull_req     (pull_req),
        .pull_len     (pull_len),
        .pull_ack     (pull_ack),
        .pull_data    (pull_data),
        .eos          (eos),
        .underflow    (underflow)
`ifdef RANS_BITREAD_STATS_EN
        ,
        .bits_consumed  (bits_consumed),
        .words_accepted (words_accepted)
`endif
    );

    typedef struct {
        logic        ready;
        logic        ack;
        logic [15:0] data;
        logic        eos;
        logic        uf;
        logic [31:0] bits;
        logic [31:0] words;
    } expRec_t;

    expRec_t expQ[$];

    // Reference model: the stream is just a queue of bits plus an end-of-stream flag.
    bit          mBits[$];
    bit          mLast;
    bit          mUnder;
    longint      mBitsCnt;
    longint      mWords;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic modelClear();
        mBits.delete();
        mLast    = 1'b0;
        mUnder   = 1'b0;
        mBitsCnt = 0;
        mWords   = 0;
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic v, input logic [31:0] w,
                                 input logic l, input logic [5:0] lb, input logic rq, input logic [4:0] ln);
        expRec_t e;
        int      len;
        int      nb;
        int      got;
        rst          = r;
        flush        = f;
        in_valid     = v;
        in_word      = w;
        in_last      = l;
        in_last_bits = lb;
        pull_req     = rq;
        pull_len     = ln;

        e.ready = !mLast && (mBits.size() <= 32);
        e.eos   = mLast && (mBits.size() == 0);
        e.uf    = mUnder;
        e.bits  = 32'(mBitsCnt);
        e.words = 32'(mWords);
        e.ack   = 1'b0;
        e.data  = '0;

        if (r || f) begin
            modelClear();
        end else begin
            len = (int'(ln) > 16) ? 16 : int'(ln);
            if (rq && ((mBits.size() >= len) || mLast)) begin
                e.ack = 1'b1;
                got   = 0;
                for (int i = 0; i < len; i++) begin
                    if (mBits.size() > 0) begin
                        e.data = {e.data[14:0], mBits.pop_front()};
                        got++;
                    end else begin
                        e.data = {e.data[14:0], 1'b0};
                        mUnder = 1'b1;
                    end
                end
                mBitsCnt = mBitsCnt + got;
                if (mBitsCnt > 64'hFFFF_FFFF) mBitsCnt = 64'hFFFF_FFFF;
            end
            if (v && e.ready) begin
                nb = (l && (lb != 0) && (lb <= 32)) ? int'(lb) : 32;
                for (int i = 0; i < nb; i++) begin
                    mBits.push_back(w[31-i]);
                end
                mWords = mWords + 1;
                if (mWords > 64'hFFFF_FFFF) mWords = 64'hFFFF_FFFF;
                if (l) mLast = 1'b1;
            end
        end

        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 32'h0, 0, 6'd0, 0, 5'd0);
    endtask

    task automatic pull(input logic [4:0] ln);
        applyStimulus(0, 0, 0, 32'h0, 0, 6'd0, 1, ln);
    endtask

    task automatic push(input logic [31:0] w);
        applyStimulus(0, 0, 1, w, 0, 6'd0, 0, 5'd0);
    endtask

    task automatic doFlush();
        applyStimulus(0, 1, 0, 32'h0, 0, 6'd0, 0, 5'd0);
    endtask

    // Monitor: outputs are compared mid-cycle against whatever the stimulus side queued.
    initial begin
        expRec_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("in_ready", 32'(in_ready), 32'(e.ready));
                checkOutput("pull_ack", 32'(pull_ack), 32'(e.ack));
                checkOutput("pull_data", 32'(pull_data), 32'(e.data));
                checkOutput("eos", 32'(eos), 32'(e.eos));
                checkOutput("underflow", 32'(underflow), 32'(e.uf));
`ifdef RANS_BITREAD_STATS_EN
                checkOutput("bits_consumed", bits_consumed, e.bits);
                checkOutput("words_accepted", words_accepted, e.words);
`endif
            end
        end
    end

    initial begin
        logic        r, f, v, l, rq;
        logic [31:0] w;
        logic [5:0]  lb;
        logic [4:0]  ln;

        modelClear();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_word = '0; in_last = 1'b0;
        in_last_bits = '0; pull_req = 1'b0; pull_len = '0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] directed: basic pulls");
        push(32'hDEADBEEF);
        pull(5'd4); pull(5'd8); pull(5'd4); pull(5'd16);
        idle(1);
        applyStimulus(1, 0, 0, 32'h0, 0, 6'd0, 0, 5'd0);
        idle(1);

        $display("[TB] directed: pull waits for data");
        pull(5'd12); pull(5'd12);
        applyStimulus(0, 0, 1, 32'hABC00000, 0, 6'd0, 1, 5'd12);
        pull(5'd12);
        pull(5'd31);
        doFlush();

        $display("[TB] directed: backpressure");
        push(32'h11112222); push(32'h33334444);
        applyStimulus(0, 0, 1, 32'h55556666, 0, 6'd0, 1, 5'd16);
        applyStimulus(0, 0, 1, 32'h55556666, 0, 6'd0, 0, 5'd0);
        applyStimulus(0, 0, 1, 32'h55556666, 0, 6'd0, 1, 5'd16);
        applyStimulus(0, 0, 1, 32'h77778888, 0, 6'd0, 0, 5'd0);
        doFlush();

        $display("[TB] directed: accept and pull together");
        push(32'hAAAA1234);
        pull(5'd16);
        applyStimulus(0, 0, 1, 32'h55550000, 0, 6'd0, 1, 5'd8);
        pull(5'd16);
        doFlush();

        $display("[TB] directed: short final word");
        applyStimulus(0, 0, 1, 32'hF0000000, 1, 6'd4, 0, 5'd0);
        pull(5'd8);
        idle(1);
        pull(5'd5);
        doFlush();
        idle(1);
        applyStimulus(0, 0, 1, 32'hF7654321, 1, 6'd12, 0, 5'd0);
        pull(5'd16);
        pull(5'd0);
        doFlush();

        $display("[TB] random phase");
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 299) == 0);
            f  = ($urandom_range(0, 59) == 0) || (mLast && (mBits.size() == 0) && ($urandom_range(0, 3) == 0));
            v  = ($urandom_range(0, 9) < 6);
            w  = $urandom;
            l  = ($urandom_range(0, 29) == 0);
            lb = 6'($urandom_range(0, 32));
            rq = ($urandom_range(0, 9) < 6);
            ln = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
            applyStimulus(r, f, v, w, l, lb, rq, ln);
        end
        idle(2);

        @(negedge clk);
        #1;
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
